// File: rtl/spi_adc_slave.sv
// spi_adc_slave
// Emulates an 8-bit serial ADC for the SPI capture master. On each chip-select
// assertion the parallel sample is frozen and shifted out MSB-first inside a
// 16-clock frame: LEAD_ZEROS zeros, DATA_BITS data bits, then zeros.
// sclk and cs_n are asynchronous to clk and are synchronized internally.
//
// Ports:
//   clk        system clock (same domain as the master)
//   n_rst      asynchronous active-low reset
//   sclk       serial clock from the master, idles high, data changes on fall
//   cs_n       chip select from the master, active low
//   sample_in  parallel sample, latched on the detected cs_n fall
//   sdata      serial data to the master
//   busy       high while a frame is in progress (equals state == SHIFT)
//   word_sent  1-clk pulse: frame ended after all data bits were shifted
//   aborted    1-clk pulse: frame ended before all data bits were shifted
//   bit_cnt    sclk falling edges counted in the current frame (saturating)
//
// Handshake: there is no valid/ready pair; cs_n delimits a frame and every
// detected sclk fall inside a frame advances the frame by exactly one bit.
module spi_adc_slave #(
  parameter int LEAD_ZEROS = 3,
  parameter int DATA_BITS  = 8,
  parameter int FRAME_BITS = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic                 sdata,
  output logic                 busy,
  output logic                 word_sent,
  output logic                 aborted,
  output logic [4:0]           bit_cnt
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [5:0] FIRST_DATA_N = 6'(LEAD_ZEROS);
  localparam logic [5:0] LAST_DATA_N  = 6'(LEAD_ZEROS + DATA_BITS);
  localparam logic [4:0] DONE_CNT     = 5'(LEAD_ZEROS + DATA_BITS);
  localparam logic [4:0] SAT_CNT      = 5'(FRAME_BITS);

  // Two synchronizer flops plus one history flop per asynchronous input.
  // All reset to 1 (the idle level) so no edge is seen right after reset.
  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_h_q  <= 1'b1;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_h_q    <= 1'b1;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
    end
  end

  logic sclk_fall, cs_fall, cs_rise;
  assign sclk_fall = sclk_h_q & ~sclk_s2_q;
  assign cs_fall   = cs_h_q & ~cs_s2_q;
  assign cs_rise   = ~cs_h_q & cs_s2_q;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic                 sdata_q, sdata_d;
  logic                 word_sent_q, word_sent_d;
  logic                 aborted_q, aborted_d;
  logic [5:0]           frame_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sdata_q     <= 1'b0;
      word_sent_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sdata_q     <= sdata_d;
      word_sent_q <= word_sent_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sdata_d     = sdata_q;
    word_sent_d = 1'b0;
    aborted_d   = 1'b0;
    // Frame number this sclk fall would start (1-based).
    frame_n     = {1'b0, bit_cnt_q} + 6'd1;

    case (state_q)
      IDLE: begin
        sdata_d = 1'b0;
        if (cs_fall) begin
          state_d   = SHIFT;
          shreg_d   = sample_in;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // cs_rise has priority over a coincident sclk_fall.
        if (cs_rise) begin
          state_d = IDLE;
          sdata_d = 1'b0;
          if (bit_cnt_q >= DONE_CNT) word_sent_d = 1'b1;
          else                       aborted_d   = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q != SAT_CNT) bit_cnt_d = bit_cnt_q + 5'd1;
          if (frame_n > FIRST_DATA_N && frame_n <= LAST_DATA_N) begin
            sdata_d = shreg_q[DATA_BITS-1];
            shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
          end else begin
            sdata_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdata     = sdata_q;
  assign busy      = (state_q == SHIFT);
  assign word_sent = word_sent_q;
  assign aborted   = aborted_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_adc_slave.sv
module tb_spi_adc_slave;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sclk = 1'b1;
  logic       cs_n = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       sdata, busy, word_sent, aborted;
  logic [4:0] bit_cnt;

  always #5 clk = ~clk;

  spi_adc_slave dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .sample_in (sample_in),
    .sdata     (sdata),
    .busy      (busy),
    .word_sent (word_sent),
    .aborted   (aborted),
    .bit_cnt   (bit_cnt)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [0:0]  exp_q[$];   // expected sdata at each master sample point
  logic [1:0]  ev_q[$];    // expected {word_sent, aborted} pulse
  logic        smp = 1'b0; // master sample strobe
  logic [14:0] rx_word = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // sdata monitor: pops an expected bit at every master sample strobe.
  always @(negedge clk) begin
    if (smp) begin
      rx_word = {rx_word[13:0], sdata};
      if (exp_q.size() == 0) check("sdata_unexpected_sample", 16'(sdata), 16'h1ff);
      else                   check("sdata_bit", 16'(sdata), 16'(exp_q.pop_front()));
    end
  end

  // Pulse monitor: every high cycle of word_sent/aborted must match one entry.
  always @(negedge clk) begin
    if (word_sent || aborted) begin
      if (ev_q.size() == 0) check("unexpected_pulse", 16'({word_sent, aborted}), 16'h0);
      else                  check("end_pulse", 16'({word_sent, aborted}), 16'(ev_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] v, input int k);
    if (k >= 4 && k <= 11) return v[11-k];
    return 1'b0;
  endfunction

  // One sclk period: low 13 clk (master samples at its end), high 12 clk.
  task automatic sclk_cycle(input logic e);
    sclk = 1'b0;
    exp_q.push_back(e);
    tick(12);
    smp = 1'b1;
    tick(1);
    smp = 1'b0;
    sclk = 1'b1;
    tick(12);
  endtask

  // Full master-style frame. chg rewrites sample_in at frame 2; b2b ends
  // with a 1-clk cs_n high gap and skips the post-frame idle checks.
  task automatic run_frame(input logic [7:0] v, input int nfall, input bit chg, input bit b2b);
    sample_in = v;
    rx_word = '0;
    cs_n = 1'b0;
    tick(12);
    for (int k = 1; k <= nfall; k++) begin
      if (chg && k == 2) sample_in = 8'hFF;
      sclk_cycle(exp_bit(v, k));
    end
    cs_n = 1'b1;
    ev_q.push_back((nfall >= 11) ? 2'b10 : 2'b01);
    if (b2b) begin
      tick(1);
    end else begin
      tick(3);
      check("busy_after_rise", 16'(busy), 16'h0);
      check("sdata_after_rise", 16'(sdata), 16'h0);
      check("bit_cnt_after_rise", 16'(bit_cnt), 16'((nfall > 16) ? 16 : nfall));
      tick(5);
    end
  endtask

  initial begin
    tick(3);
    check("rst_sdata", 16'(sdata), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_bit_cnt", 16'(bit_cnt), 16'h0);
    check("rst_pulses", 16'({word_sent, aborted}), 16'h0);
    n_rst = 1'b1;
    tick(5);

    // Normal 15-fall frame with A5, reassembled by the master model.
    run_frame(8'hA5, 15, 1'b0, 1'b0);
    check("rx_word_a5", 16'(rx_word[11:4]), 16'h00A5);

    // sample_in changes mid-frame must not leak into the shifted data.
    run_frame(8'h3C, 15, 1'b1, 1'b0);
    check("rx_word_3c", 16'(rx_word[11:4]), 16'h003C);

    // Early release after 6 falls.
    run_frame(8'hC3, 6, 1'b0, 1'b0);

    // sclk toggling with cs_n high: nothing moves.
    for (int k = 0; k < 5; k++) sclk_cycle(1'b0);
    check("idle_bit_cnt", 16'(bit_cnt), 16'h6);
    check("idle_busy", 16'(busy), 16'h0);
    check("idle_sdata", 16'(sdata), 16'h0);

    // Reset in the middle of frame 7.
    sample_in = 8'h5A;
    cs_n = 1'b0;
    tick(12);
    for (int k = 1; k <= 6; k++) sclk_cycle(exp_bit(8'h5A, k));
    sclk = 1'b0;
    tick(6);
    check("pre_rst_busy", 16'(busy), 16'h1);
    check("pre_rst_bit_cnt", 16'(bit_cnt), 16'h7);
    check("pre_rst_sdata", 16'(sdata), 16'(exp_bit(8'h5A, 7)));
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_sdata", 16'(sdata), 16'h0);
    check("async_rst_busy", 16'(busy), 16'h0);
    check("async_rst_bit_cnt", 16'(bit_cnt), 16'h0);
    check("async_rst_pulses", 16'({word_sent, aborted}), 16'h0);
    sclk = 1'b1;
    cs_n = 1'b1;
    tick(3);
    n_rst = 1'b1;
    tick(5);
    run_frame(8'h81, 15, 1'b0, 1'b0);
    check("rx_word_81", 16'(rx_word[11:4]), 16'h0081);

    // Back-to-back FF then 00, 1-clk cs_n high gap.
    run_frame(8'hFF, 15, 1'b0, 1'b1);
    check("rx_word_ff", 16'(rx_word[11:4]), 16'h00FF);
    run_frame(8'h00, 15, 1'b0, 1'b0);
    check("rx_word_00", 16'(rx_word[11:4]), 16'h0000);

    tick(10);
    check("sdata_queue_drained", 16'(exp_q.size()), 16'h0);
    check("pulse_queue_drained", 16'(ev_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
